// File: rtl/urv_scoreboard_pkg.sv
// Shared constants for the uRV register-hazard scoreboard: instruction
// class codes, countdown width and the class-to-latency lookup.
package urv_scoreboard_pkg;

  localparam int SB_CNT_W = 4;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam logic [2:0] SB_CLASS_ALU    = 3'd0;
  localparam logic [2:0] SB_CLASS_LOAD   = 3'd1;
  localparam logic [2:0] SB_CLASS_SHIFT  = 3'd2;
  localparam logic [2:0] SB_CLASS_MUL    = 3'd3;
  localparam logic [2:0] SB_CLASS_MULH   = 3'd4;
  localparam logic [2:0] SB_CLASS_DIV    = 3'd5;
  localparam logic [2:0] SB_CLASS_SYSTEM = 3'd6;

  // Countdown for a class; DIV, ALU, SYSTEM and unused codes return 0
  // (DIV is tracked by handshake, not by counting).
  function automatic sb_cnt_t sb_lat(input logic [2:0] cls,
                                     input sb_cnt_t   l_load,
                                     input sb_cnt_t   l_shift,
                                     input sb_cnt_t   l_mul,
                                     input sb_cnt_t   l_mulh);
    sb_cnt_t l;
    case (cls)
      SB_CLASS_LOAD:  l = l_load;
      SB_CLASS_SHIFT: l = l_shift;
      SB_CLASS_MUL:   l = l_mul;
      SB_CLASS_MULH:  l = l_mulh;
      default:        l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/urv_scoreboard_entry.sv
// One scoreboard slot: holds a destination register, counts down its
// remaining latency (or waits for the divider) and reports address hits.
module urv_sb_entry
  import urv_scoreboard_pkg::*;
#(
  parameter int g_reg_aw = 5
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [g_reg_aw-1:0] rd_i,
  input  sb_cnt_t             cnt_i,
  input  logic                is_div_i,
  input  logic                tick_i,
  input  logic                div_done_i,
  input  logic [g_reg_aw-1:0] rs1_i,
  input  logic [g_reg_aw-1:0] rs2_i,
  input  logic [g_reg_aw-1:0] chk_rd_i,
  output logic                valid_o,
  output logic                is_div_o,
  output logic [g_reg_aw-1:0] rd_o,
  output logic                rs1_hit_o,
  output logic                rs2_hit_o,
  output logic                rd_hit_o
);

  logic                valid_q, valid_d;
  logic                is_div_q, is_div_d;
  logic [g_reg_aw-1:0] rd_q, rd_d;
  sb_cnt_t             cnt_q, cnt_d;

  // Next state: load wins (slot is free when loaded), div slots wait for
  // the done pulse, counting slots decrement and free on the 1->0 step.
  always_comb begin
    valid_d  = valid_q;
    is_div_d = is_div_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      valid_d  = 1'b1;
      is_div_d = is_div_i;
      rd_d     = rd_i;
      cnt_d    = cnt_i;
    end else if (valid_q && is_div_q) begin
      if (div_done_i) valid_d = 1'b0;
    end else if (valid_q && tick_i) begin
      cnt_d = cnt_q - sb_cnt_t'(1);
      if (cnt_q == sb_cnt_t'(1)) valid_d = 1'b0;
    end
  end

  // Slot state; reset drops any tracking immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      is_div_q <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      is_div_q <= is_div_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o   = valid_q;
  assign is_div_o  = is_div_q;
  assign rd_o      = rd_q;
  assign rs1_hit_o = valid_q && (rd_q == rs1_i);
  assign rs2_hit_o = valid_q && (rd_q == rs2_i);
  assign rd_hit_o  = valid_q && (rd_q == chk_rd_i);

endmodule

// File: rtl/urv_scoreboard.sv
// Decode-stage hazard scoreboard: a table of in-flight destination
// registers; stalls decode on RAW/WAW hits, a full table or a busy divider.
module urv_scoreboard
  import urv_scoreboard_pkg::*;
#(
  parameter int g_reg_aw      = 5,
  parameter int g_depth       = 4,
  parameter int g_lat_load    = 1,
  parameter int g_lat_shift   = 1,
  parameter int g_lat_mul     = 1,
  parameter int g_lat_mulh    = 2,
  parameter int g_with_hw_div = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     d_valid_i,
  input  logic                     d_stall_i,
  input  logic                     d_kill_i,
  input  logic [g_reg_aw-1:0]      d_rs1_i,
  input  logic [g_reg_aw-1:0]      d_rs2_i,
  input  logic [g_reg_aw-1:0]      d_rd_i,
  input  logic                     d_use_rs1_i,
  input  logic                     d_use_rs2_i,
  input  logic                     d_rd_write_i,
  input  logic [2:0]               d_class_i,
  input  logic                     div_done_i,
  output logic                     d_stall_req_o,
  output logic [2**g_reg_aw-1:0]   sb_pending_o,
  output logic [3:0]               sb_count_o
);

  logic [g_depth-1:0]               valid, is_div, hit1, hit2, hitd, alloc;
  logic [g_depth-1:0][g_reg_aw-1:0] rd;
  sb_cnt_t                          lat;
  logic                             div_cls, need, issue, raw, waw, full, div_busy;

  assign lat = sb_lat(d_class_i, sb_cnt_t'(g_lat_load), sb_cnt_t'(g_lat_shift),
                      sb_cnt_t'(g_lat_mul), sb_cnt_t'(g_lat_mulh));
  assign div_cls = (g_with_hw_div != 0) && (d_class_i == SB_CLASS_DIV);
  assign need    = d_rd_write_i && (d_rd_i != '0) && ((lat != '0) || div_cls);

  // Hazard detection against registered entries only; purely combinational
  // from the decode inputs so the stall is available in the same cycle.
  always_comb begin
    raw      = (d_use_rs1_i && (d_rs1_i != '0) && (|hit1)) ||
               (d_use_rs2_i && (d_rs2_i != '0) && (|hit2));
    waw      = d_rd_write_i && (d_rd_i != '0) && (|hitd);
    full     = &valid;
    div_busy = div_cls && (|(valid & is_div));
    d_stall_req_o = d_valid_i && !d_kill_i && (raw || waw || (need && full) || div_busy);
    issue    = d_valid_i && !d_stall_i && !d_kill_i && !d_stall_req_o;
  end

  // Lowest-index free slot gets the new destination.
  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < g_depth; i++) begin
      if (!found && !valid[i]) begin
        alloc[i] = issue && need;
        found    = 1'b1;
      end
    end
  end

  // Bitmap and occupancy count derived from the entry table.
  always_comb begin
    sb_pending_o = '0;
    sb_count_o   = '0;
    for (int i = 0; i < g_depth; i++) begin
      if (valid[i]) begin
        sb_pending_o[rd[i]] = 1'b1;
        sb_count_o          = sb_count_o + 4'd1;
      end
    end
    sb_pending_o[0] = 1'b0;
  end

  for (genvar g = 0; g < g_depth; g++) begin : g_ent
    urv_sb_entry #(.g_reg_aw(g_reg_aw)) u_ent (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (alloc[g]),
      .rd_i       (d_rd_i),
      .cnt_i      (lat),
      .is_div_i   (div_cls),
      .tick_i     (!d_stall_i),
      .div_done_i (div_done_i),
      .rs1_i      (d_rs1_i),
      .rs2_i      (d_rs2_i),
      .chk_rd_i   (d_rd_i),
      .valid_o    (valid[g]),
      .is_div_o   (is_div[g]),
      .rd_o       (rd[g]),
      .rs1_hit_o  (hit1[g]),
      .rs2_hit_o  (hit2[g]),
      .rd_hit_o   (hitd[g])
    );
  end

endmodule

// File: tb/tb_urv_scoreboard.sv
// Directed bench for urv_scoreboard: each instruction pushes its expected
// stall-cycle count and the count seen before issue is popped and compared.
module tb_urv_scoreboard;
  import urv_scoreboard_pkg::*;

  logic        clk, rst_n;
  logic        d_valid, d_stall, d_kill, d_use1, d_use2, d_wr, div_done;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [2:0]  d_class;
  logic        stall_req;
  logic [31:0] pending;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  // Latencies chosen so one table fills with 4 MULs (lat 4) and the
  // load-use and MULH cases keep their 1- and 2-cycle stalls.
  urv_scoreboard #(
    .g_reg_aw(5), .g_depth(4), .g_lat_load(1), .g_lat_shift(1),
    .g_lat_mul(4), .g_lat_mulh(2), .g_with_hw_div(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_stall_i(d_stall),
    .d_kill_i(d_kill), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_rd_i(d_rd),
    .d_use_rs1_i(d_use1), .d_use_rs2_i(d_use2), .d_rd_write_i(d_wr),
    .d_class_i(d_class), .div_done_i(div_done), .d_stall_req_o(stall_req),
    .sb_pending_o(pending), .sb_count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] cls, input logic [4:0] rd, input logic wr,
                           input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
    d_valid = 1'b1; d_class = cls; d_rd = rd; d_wr = wr;
    d_rs1 = rs1; d_use1 = u1; d_rs2 = rs2; d_use2 = u2;
  endtask

  // Present one instruction, count stall cycles until it issues (bounded).
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic wr,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input int exp, input string tag);
    int n;
    exp_q.push_back(exp);
    set_instr(cls, rd, wr, rs1, u1, rs2, u2);
    n = 0;
    @(negedge clk);
    while (stall_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
    check(tag, n, exp_q.pop_front());
  endtask

  initial begin
    int n, cyc;
    rst_n = 1'b0; d_valid = 0; d_stall = 0; d_kill = 0; d_use1 = 0; d_use2 = 0;
    d_wr = 0; div_done = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_class = SB_CLASS_ALU;
    #3;
    check("reset_count", count, 0);
    check("reset_pending", pending, 0);
    check("reset_stall", stall_req, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Load-use
    send(SB_CLASS_LOAD, 5, 1, 0, 0, 0, 0, 0, "load_x5_issue");
    check("load_pending5", pending[5], 1);
    check("load_count", count, 1);
    send(SB_CLASS_ALU, 6, 1, 5, 1, 0, 0, 1, "load_use_stall");
    check("load_use_pending_clear", pending, 0);

    // MULH dependency with 3-cycle global stall mid-countdown
    send(SB_CLASS_MULH, 7, 1, 0, 0, 0, 0, 0, "mulh_issue");
    exp_q.push_back(5);
    set_instr(SB_CLASS_ALU, 8, 1, 0, 0, 7, 1);
    n = 0; cyc = 0;
    while (n < 40) begin
      d_stall = (cyc >= 1 && cyc <= 3);
      @(negedge clk);
      if (!stall_req) break;
      n++;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    d_valid = 0;
    check("mulh_gstall_len", n, exp_q.pop_front());

    // Full table: four MULs, fifth waits for the oldest slot to free
    send(SB_CLASS_MUL, 1, 1, 0, 0, 0, 0, 0, "mul_x1");
    send(SB_CLASS_MUL, 2, 1, 0, 0, 0, 0, 0, "mul_x2");
    send(SB_CLASS_MUL, 3, 1, 0, 0, 0, 0, 0, "mul_x3");
    send(SB_CLASS_MUL, 4, 1, 0, 0, 0, 0, 0, "mul_x4");
    check("full_count", count, 4);
    check("full_pending", pending, 32'h0000_001e);
    send(SB_CLASS_MUL, 10, 1, 0, 0, 0, 0, 1, "full_stall");
    check("full_after_count", count, 3);
    idle(6);
    check("full_drained", count, 0);

    // Divider
    send(SB_CLASS_DIV, 9, 1, 0, 0, 0, 0, 0, "div_issue");
    check("div_pending9", pending, 32'h0000_0200);
    set_instr(SB_CLASS_ALU, 12, 1, 9, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("div_raw_stall", stall_req, 1);
      @(posedge clk); #1;
    end
    set_instr(SB_CLASS_DIV, 11, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("div_busy_stall", stall_req, 1);
    @(posedge clk); #1;
    set_instr(SB_CLASS_ALU, 12, 1, 9, 1, 0, 0);
    div_done = 1'b1;
    @(negedge clk);
    check("div_done_same_cycle", stall_req, 1);
    @(posedge clk); #1 div_done = 1'b0;
    @(negedge clk);
    check("div_released", stall_req, 0);
    @(posedge clk); #1 d_valid = 0;
    check("div_count_after", count, 0);
    div_done = 1'b1; idle(1); div_done = 1'b0;
    check("stray_done_count", count, 0);
    send(SB_CLASS_DIV, 13, 1, 0, 0, 0, 0, 0, "div2_issue");
    idle(3);
    check("div2_held", count, 1);
    div_done = 1'b1; idle(1); div_done = 1'b0;
    check("div2_cleared", count, 0);

    // Kill, x0, WAW
    set_instr(SB_CLASS_LOAD, 4, 1, 0, 0, 0, 0);
    d_kill = 1'b1;
    @(negedge clk);
    check("kill_no_stall", stall_req, 0);
    @(posedge clk); #1 d_kill = 0; d_valid = 0;
    check("kill_no_entry", count, 0);
    send(SB_CLASS_LOAD, 0, 1, 0, 0, 0, 0, 0, "load_x0");
    check("x0_no_entry", count, 0);
    send(SB_CLASS_ALU, 3, 1, 0, 1, 0, 1, 0, "x0_reader");
    send(SB_CLASS_LOAD, 4, 1, 0, 0, 0, 0, 0, "load_x4");
    send(SB_CLASS_LOAD, 4, 1, 0, 0, 0, 0, 1, "waw_x4");
    idle(2);
    check("waw_drained", count, 0);

    // Asynchronous reset with DIV + three MULs pending
    send(SB_CLASS_DIV, 9, 1, 0, 0, 0, 0, 0, "rst_div");
    send(SB_CLASS_MUL, 1, 1, 0, 0, 0, 0, 0, "rst_mul1");
    send(SB_CLASS_MUL, 2, 1, 0, 0, 0, 0, 0, "rst_mul2");
    send(SB_CLASS_MUL, 3, 1, 0, 0, 0, 0, 0, "rst_mul3");
    check("pre_rst_count", count, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_pending", pending, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(SB_CLASS_ALU, 5, 1, 9, 1, 1, 1, 0, "post_rst_reader_a");
    send(SB_CLASS_ALU, 6, 1, 3, 1, 2, 1, 0, "post_rst_reader_b");
    div_done = 1'b1; idle(1); div_done = 1'b0;
    check("post_rst_stray_done", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
